// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Counts synchronized rising edges of sig_in over a fixed gate
//               window of GATE_CYCLES clk_in cycles. FREQ_METER_DUTY_EN adds
//               a high-time counter (high_cnt) for duty-cycle measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  continuous,
    input  logic                                  sig_in,
    output logic                                  busy,
    output logic                                  valid,
    output logic [CNT_W-1:0]                      freq_cnt,
    output logic                                  overflow
`ifdef FREQ_METER_DUTY_EN
    ,
    output logic [$clog2(GATE_CYCLES+1)-1:0]      high_cnt
`endif
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int HW = $clog2(GATE_CYCLES + 1);

    localparam logic [GW-1:0]    c_GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GATE  = 2'd1;
    localparam logic [1:0] c_LATCH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             sync1_q, sync2_q, dly_q;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             w_edge;
    logic             w_arm;
`ifdef FREQ_METER_DUTY_EN
    logic [HW-1:0]    acc_q, acc_d;
    logic [HW-1:0]    high_q, high_d;
`endif

    assign w_edge = sync2_q & ~dly_q;

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        w_arm      = 1'b0;
`ifdef FREQ_METER_DUTY_EN
        acc_d      = acc_q;
        high_d     = high_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_GATE;
                    w_arm   = 1'b1;
                end
            end
            c_GATE: begin
                gate_d = gate_q + 1'b1;
                // Saturate rather than wrap; the flag records that an edge was lost.
                if (w_edge) begin
                    if (edge_cnt_q == c_CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
`ifdef FREQ_METER_DUTY_EN
                if (sync2_q) begin
                    acc_d = acc_q + 1'b1;
                end
`endif
                if (gate_q == c_GATE_LAST) begin
                    state_d = c_LATCH;
                end
            end
            c_LATCH: begin
                freq_d  = edge_cnt_q;
                ovf_d   = sat_q;
                valid_d = 1'b1;
`ifdef FREQ_METER_DUTY_EN
                high_d  = acc_q;
`endif
                if (continuous) begin
                    state_d = c_GATE;
                    w_arm   = 1'b1;
                end else begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // A new gate always starts from cleared counters.
        if (w_arm) begin
            gate_d     = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
`ifdef FREQ_METER_DUTY_EN
            acc_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            dly_q      <= 1'b0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
            acc_q      <= '0;
            high_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= sig_in;
            sync2_q    <= sync1_q;
            dly_q      <= sync2_q;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
`ifdef FREQ_METER_DUTY_EN
            acc_q      <= acc_d;
            high_q     <= high_d;
`endif
        end
    end

    assign busy     = (state_q != c_IDLE);
    assign valid    = valid_q;
    assign freq_cnt = freq_q;
    assign overflow = ovf_q;
`ifdef FREQ_METER_DUTY_EN
    assign high_cnt = high_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Scoreboard bench for freq_meter (GATE_CYCLES=100) using an
//               8-bit and a 4-bit counter instance driven by the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

    localparam int c_GATE = 100;
    localparam int c_HW   = $clog2(c_GATE + 1);

    logic       clk_in;
    logic       rst_n;
    logic       start;
    logic       continuous;
    logic       sig_in;
    logic       busy8, valid8, ovf8;
    logic       busy4, valid4, ovf4;
    logic [7:0] freq8;
    logic [3:0] freq4;
`ifdef FREQ_METER_DUTY_EN
    logic [c_HW-1:0] high8, high4;
`endif

    typedef struct {
        int f8;
        int o8;
        int f4;
        int o4;
        int hi;
    } exp_t;

    exp_t sb[$];
    exp_t r_got;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   valid_cnt;
    int   sig_period;
    int   sig_high;
    logic sig_level;
    int   ph;

    freq_meter #(.GATE_CYCLES(c_GATE), .CNT_W(8)) u_dut8 (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .continuous(continuous),
        .sig_in(sig_in), .busy(busy8), .valid(valid8), .freq_cnt(freq8),
        .overflow(ovf8)
`ifdef FREQ_METER_DUTY_EN
        , .high_cnt(high8)
`endif
    );

    freq_meter #(.GATE_CYCLES(c_GATE), .CNT_W(4)) u_dut4 (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .continuous(continuous),
        .sig_in(sig_in), .busy(busy4), .valid(valid4), .freq_cnt(freq4),
        .overflow(ovf4)
`ifdef FREQ_METER_DUTY_EN
        , .high_cnt(high4)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_in);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int f8, input int o8, input int f4, input int o4, input int hi);
        exp_t e;
        e.f8 = f8; e.o8 = o8; e.f4 = f4; e.o4 = o4; e.hi = hi;
        return e;
    endfunction

    // Synchronous periodic source: period dividing the gate gives an exact count.
    initial begin
        sig_in = 1'b0;
        ph     = 0;
        forever begin
            @(negedge clk_in);
            if (sig_period == 0) begin
                sig_in = sig_level;
            end else begin
                ph     = (ph + 1 >= sig_period) ? 0 : ph + 1;
                sig_in = (ph < sig_high);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (valid8) begin
                valid_cnt++;
                check_eq("valid4_with_valid8", int'(valid4), 1);
                check_eq("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    r_got = sb.pop_front();
                    check_eq("freq8", int'(freq8), r_got.f8);
                    check_eq("ovf8",  int'(ovf8),  r_got.o8);
                    check_eq("freq4", int'(freq4), r_got.f4);
                    check_eq("ovf4",  int'(ovf4),  r_got.o4);
`ifdef FREQ_METER_DUTY_EN
                    check_eq("high8", int'(high8), r_got.hi);
                    check_eq("high4", int'(high4), r_got.hi);
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic set_sig(input int p, input int h, input logic l);
        sig_period = p;
        sig_high   = h;
        sig_level  = l;
    endtask

    // Returns the cycle index seen at the negedge following the sampling posedge.
    task automatic pulse_start(output int cs);
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        cs = cyc;
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (valid8) begin
                at = cyc;
                break;
            end
        end
        check_eq("valid_seen", int'(at >= 0), 1);
    endtask

    task automatic run_single(input exp_t e, input string tag);
        int cs, at, v0;
        repeat (30) @(negedge clk_in);
        v0 = valid_cnt;
        sb.push_back(e);
        pulse_start(cs);
        wait_valid(300, at);
        check_eq({tag, "_latency"}, at - cs, c_GATE + 1);
        repeat (20) @(negedge clk_in);
        check_eq({tag, "_nvalid"}, valid_cnt - v0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  int'(busy8), 0);
        check_eq({tag, "_valid"}, int'(valid8), 0);
        check_eq({tag, "_freq8"}, int'(freq8), 0);
        check_eq({tag, "_ovf8"},  int'(ovf8), 0);
        check_eq({tag, "_freq4"}, int'(freq4), 0);
        check_eq({tag, "_ovf4"},  int'(ovf4), 0);
`ifdef FREQ_METER_DUTY_EN
        check_eq({tag, "_high8"}, int'(high8), 0);
`endif
    endtask

    initial begin
        int cs, nb, v0, c0, c1, c2, dummy;
        n_tests    = 0;
        n_fail     = 0;
        valid_cnt  = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        set_sig(0, 0, 1'b0);

        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single shot, period 10, 50% duty.
        set_sig(10, 5, 1'b0);
        repeat (50) @(negedge clk_in);
        v0 = valid_cnt;
        sb.push_back(mk(10, 0, 10, 0, 50));
        pulse_start(cs);
        nb = 0;
        for (int i = 0; i < 300 && busy8; i++) begin
            nb++;
            @(negedge clk_in);
        end
        check_eq("single_busy_len", nb, c_GATE + 1);
        check_eq("single_valid_at_idle", int'(valid8), 1);
        check_eq("single_latency", cyc - cs, c_GATE + 1);
        @(negedge clk_in);
        check_eq("single_valid_pulse", int'(valid8), 0);
        repeat (20) @(negedge clk_in);
        check_eq("single_nvalid", valid_cnt - v0, 1);

        // Continuous, period 4; the 4-bit instance saturates at 15.
        set_sig(4, 2, 1'b0);
        repeat (50) @(negedge clk_in);
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) sb.push_back(mk(25, 0, 15, 1, 50));
        continuous = 1'b1;
        pulse_start(cs);
        wait_valid(300, c0);
        check_eq("cont_first", c0 - cs, c_GATE + 1);
        wait_valid(300, c1);
        check_eq("cont_period1", c1 - c0, c_GATE + 1);
        repeat (40) @(negedge clk_in);
        continuous = 1'b0;
        wait_valid(300, c2);
        check_eq("cont_period2", c2 - c1, c_GATE + 1);
        check_eq("cont_idle_busy", int'(busy8), 0);
        repeat (250) @(negedge clk_in);
        check_eq("cont_nvalid", valid_cnt - v0, 3);
        check_eq("cont_sb_drained", sb.size(), 0);

        // Recovery from saturation with a slow input.
        set_sig(20, 10, 1'b0);
        run_single(mk(5, 0, 5, 0, 50), "sat_recover");

        // Start pulse during gate is ignored.
        set_sig(10, 5, 1'b0);
        repeat (30) @(negedge clk_in);
        v0 = valid_cnt;
        sb.push_back(mk(10, 0, 10, 0, 50));
        pulse_start(cs);
        repeat (29) @(negedge clk_in);
        pulse_start(dummy);
        wait_valid(300, c0);
        check_eq("ignore_latency", c0 - cs, c_GATE + 1);
        repeat (150) @(negedge clk_in);
        check_eq("ignore_nvalid", valid_cnt - v0, 1);

        // Asynchronous reset in the middle of a gate.
        repeat (30) @(negedge clk_in);
        v0 = valid_cnt;
        pulse_start(cs);
        repeat (50) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (200) @(negedge clk_in);
        check_eq("midreset_novalid", valid_cnt - v0, 0);
        run_single(mk(10, 0, 10, 0, 50), "after_reset");

        // DC inputs.
        set_sig(0, 0, 1'b0);
        run_single(mk(0, 0, 0, 0, 0), "dc_low");
        set_sig(0, 0, 1'b1);
        run_single(mk(0, 0, 0, 0, c_GATE), "dc_high");

        check_eq("final_sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
